// File: rtl/wb_arbiter_if.sv
// rtl/wb_arbiter_if.sv - execution-unit result bus and retire/redirect outputs of the write-back stage
interface wb_arbiter_if #(
  parameter int XLEN    = 32,
  parameter int NUM_SRC = 3
);
  logic [NUM_SRC-1:0]      src_valid;
  logic [NUM_SRC-1:0]      src_ready;
  logic [NUM_SRC*XLEN-1:0] src_result;
  logic [NUM_SRC*5-1:0]    src_rd;
  logic [NUM_SRC-1:0]      src_result_v;
  logic [NUM_SRC-1:0]      src_exception;
  logic [NUM_SRC*XLEN-1:0] src_target;
  logic                    rf_we;
  logic [4:0]              rf_waddr;
  logic [XLEN-1:0]         rf_wdata;
  logic                    instret_v;
  logic                    redirect_v;
  logic [XLEN-1:0]         redirect_target;
  logic                    flush_o;

  modport slave (
    input  src_valid, src_result, src_rd, src_result_v, src_exception, src_target,
    output src_ready, rf_we, rf_waddr, rf_wdata, instret_v, redirect_v, redirect_target, flush_o
  );

  modport master (
    output src_valid, src_result, src_rd, src_result_v, src_exception, src_target,
    input  src_ready, rf_we, rf_waddr, rf_wdata, instret_v, redirect_v, redirect_target, flush_o
  );
endinterface

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - round-robin write-back arbiter with exception redirect and flush drain
module wb_arbiter #(
  parameter int XLEN         = 32,
  parameter int NUM_SRC      = 3,
  parameter int FLUSH_CYCLES = 2
) (
  input logic         clk,
  input logic         rst,
  wb_arbiter_if.slave bus
);
  localparam int PW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int CW = $clog2(FLUSH_CYCLES + 1);

  typedef enum logic {RUN, FLUSH} state_t;

  state_t          state, state_next;
  logic [CW-1:0]   cnt, cnt_next;
  logic [PW-1:0]   rr_ptr, rr_next;
  logic [PW-1:0]   grant, scan_idx;
  logic            any_valid;
  logic [NUM_SRC-1:0] ready;

  logic            we_next, inst_next, redir_next, flush_next;
  logic [4:0]      waddr_next;
  logic [XLEN-1:0] wdata_next, tgt_next;

  logic [XLEN-1:0] res_a [NUM_SRC];
  logic [XLEN-1:0] tgt_a [NUM_SRC];
  logic [4:0]      rd_a  [NUM_SRC];

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_unpack
    assign res_a[i] = bus.src_result[i*XLEN +: XLEN];
    assign tgt_a[i] = bus.src_target[i*XLEN +: XLEN];
    assign rd_a[i]  = bus.src_rd[i*5 +: 5];
  end

  // First valid source scanning upward from rr_ptr, wrapping modulo NUM_SRC.
  always_comb begin
    grant     = '0;
    scan_idx  = '0;
    any_valid = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      scan_idx = PW'((int'(rr_ptr) + k) % NUM_SRC);
      if (!any_valid && bus.src_valid[scan_idx]) begin
        any_valid = 1'b1;
        grant     = scan_idx;
      end
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    rr_next    = rr_ptr;
    ready      = '0;
    we_next    = 1'b0;
    inst_next  = 1'b0;
    redir_next = 1'b0;
    flush_next = 1'b0;
    waddr_next = bus.rf_waddr;
    wdata_next = bus.rf_wdata;
    tgt_next   = bus.redirect_target;
    case (state)
      RUN: begin
        if (any_valid) begin
          ready   = NUM_SRC'(1) << grant;
          rr_next = (grant == PW'(NUM_SRC - 1)) ? '0 : grant + PW'(1);
          if (bus.src_exception[grant]) begin
            redir_next = 1'b1;
            tgt_next   = tgt_a[grant];
            flush_next = 1'b1;
            state_next = FLUSH;
            cnt_next   = CW'(FLUSH_CYCLES);
          end else begin
            inst_next = 1'b1;
            if (bus.src_result_v[grant] && rd_a[grant] != 5'd0) begin
              we_next    = 1'b1;
              waddr_next = rd_a[grant];
              wdata_next = res_a[grant];
            end
          end
        end
      end
      FLUSH: begin
        // Counter holds drain cycles still to come after this one.
        ready = '1;
        if (cnt == '0) begin
          state_next = RUN;
        end else begin
          cnt_next   = cnt - CW'(1);
          flush_next = 1'b1;
        end
      end
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state               <= RUN;
      cnt                 <= '0;
      rr_ptr              <= '0;
      bus.rf_we           <= 1'b0;
      bus.rf_waddr        <= '0;
      bus.rf_wdata        <= '0;
      bus.instret_v       <= 1'b0;
      bus.redirect_v      <= 1'b0;
      bus.redirect_target <= '0;
      bus.flush_o         <= 1'b0;
    end else begin
      state               <= state_next;
      cnt                 <= cnt_next;
      rr_ptr              <= rr_next;
      bus.rf_we           <= we_next;
      bus.rf_waddr        <= waddr_next;
      bus.rf_wdata        <= wdata_next;
      bus.instret_v       <= inst_next;
      bus.redirect_v      <= redir_next;
      bus.redirect_target <= tgt_next;
      bus.flush_o         <= flush_next;
    end
  end

  assign bus.src_ready = ready;
endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - scoreboard bench for wb_arbiter against a cycle-level reference model
module tb_wb_arbiter;
  localparam int XLEN = 32;
  localparam int N    = 3;
  localparam int FC   = 2;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  wb_arbiter_if #(.XLEN(XLEN), .NUM_SRC(N)) bus ();

  wb_arbiter #(.XLEN(XLEN), .NUM_SRC(N), .FLUSH_CYCLES(FC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] ready;
    bit           chk;
  } ready_rec_t;

  typedef struct {
    logic            we;
    logic [4:0]      waddr;
    logic [XLEN-1:0] wdata;
    logic            inst;
    logic            redir;
    logic [XLEN-1:0] tgt;
    logic            flush;
  } out_rec_t;

  ready_rec_t ready_q[$];
  out_rec_t   out_q[$];

  // Reference state: next grant start, cycles of drain remaining, held write port values.
  int              m_rr;
  int              m_drain;
  logic [4:0]      m_waddr;
  logic [XLEN-1:0] m_wdata;
  logic [XLEN-1:0] m_tgt;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    ready_rec_t rr;
    out_rec_t   o;
    int         g;
    logic [N-1:0]        v;
    logic [N*XLEN-1:0]   res;
    logic [N*XLEN-1:0]   tgt;
    logic [N*5-1:0]      rd;
    v   = bus.src_valid;
    res = bus.src_result;
    tgt = bus.src_target;
    rd  = bus.src_rd;
    rr.ready = '0;
    rr.chk   = 1'b1;
    o.we = 0; o.inst = 0; o.redir = 0; o.flush = 0;
    if (rst) begin
      rr.chk  = 1'b0;
      m_rr    = 0;
      m_drain = 0;
      m_waddr = '0;
      m_wdata = '0;
      m_tgt   = '0;
    end else if (m_drain > 0) begin
      rr.ready = '1;
      o.flush  = (m_drain > 1);
      m_drain--;
    end else begin
      g = -1;
      for (int k = 0; k < N; k++)
        if (g < 0 && v[(m_rr + k) % N]) g = (m_rr + k) % N;
      if (g >= 0) begin
        rr.ready = '0;
        rr.ready[g] = 1'b1;
        m_rr = (g + 1) % N;
        if (bus.src_exception[g]) begin
          o.redir = 1;
          o.flush = 1;
          m_tgt   = tgt[g*XLEN +: XLEN];
          m_drain = FC + 1;
        end else begin
          o.inst = 1;
          if (bus.src_result_v[g] && rd[g*5 +: 5] != 5'd0) begin
            o.we    = 1;
            m_waddr = rd[g*5 +: 5];
            m_wdata = res[g*XLEN +: XLEN];
          end
        end
      end
    end
    o.waddr = m_waddr;
    o.wdata = m_wdata;
    o.tgt   = m_tgt;
    ready_q.push_back(rr);
    out_q.push_back(o);
  endtask

  task automatic drive(input logic [N-1:0] v, input logic [N-1:0] rv, input logic [N-1:0] ex,
                       input logic [N*5-1:0] rd, input logic [N*XLEN-1:0] res,
                       input logic [N*XLEN-1:0] tgt, input logic r);
    @(posedge clk);
    #2;
    rst               = r;
    bus.src_valid     = v;
    bus.src_result_v  = rv;
    bus.src_exception = ex;
    bus.src_rd        = rd;
    bus.src_result    = res;
    bus.src_target    = tgt;
    model_step();
  endtask

  always @(negedge clk) begin
    ready_rec_t r;
    out_rec_t   e;
    if (ready_q.size() > 0) begin
      r = ready_q.pop_front();
      if (r.chk) check("src_ready", 64'(bus.src_ready), 64'(r.ready));
    end
    if (out_q.size() > 1) begin
      e = out_q.pop_front();
      check("rf_we", 64'(bus.rf_we), 64'(e.we));
      check("rf_waddr", 64'(bus.rf_waddr), 64'(e.waddr));
      check("rf_wdata", 64'(bus.rf_wdata), 64'(e.wdata));
      check("instret_v", 64'(bus.instret_v), 64'(e.inst));
      check("redirect_v", 64'(bus.redirect_v), 64'(e.redir));
      check("flush_o", 64'(bus.flush_o), 64'(e.flush));
      if (e.redir) check("redirect_target", 64'(bus.redirect_target), 64'(e.tgt));
    end
  end

  initial begin
    logic [N*5-1:0]    rd;
    logic [N*XLEN-1:0] res;
    logic [N*XLEN-1:0] tgt;
    logic [N-1:0]      ex;
    rst = 1'b1;
    bus.src_valid = '0; bus.src_result_v = '0; bus.src_exception = '0;
    bus.src_rd = '0; bus.src_result = '0; bus.src_target = '0;
    m_rr = 0; m_drain = 0; m_waddr = '0; m_wdata = '0; m_tgt = '0;

    drive('0, '0, '0, '0, '0, '0, 1'b1);
    drive('0, '0, '0, '0, '0, '0, 1'b1);
    drive('0, '0, '0, '0, '0, '0, 1'b0);

    // Single ALU result
    rd = '0;  rd[4:0] = 5'd5;
    res = '0; res[31:0] = 32'hDEADBEEF;
    drive(3'b001, 3'b001, 3'b000, rd, res, '0, 1'b0);
    drive('0, '0, '0, rd, res, '0, 1'b0);
    drive('0, '0, '0, rd, res, '0, 1'b0);

    // Fairness with all sources continuously valid
    rd = {5'd3, 5'd2, 5'd1};
    res = {32'h2222_0000, 32'h1111_0000, 32'h0000_AAAA};
    for (int i = 0; i < 6; i++) begin
      res = res + {32'd1, 32'd1, 32'd1};
      drive(3'b111, 3'b111, 3'b000, rd, res, '0, 1'b0);
    end

    // CSR write to x0 retires without writing
    rd = {5'd0, 5'd7, 5'd8};
    drive(3'b100, 3'b100, 3'b000, rd, res, '0, 1'b0);
    drive('0, '0, '0, rd, res, '0, 1'b0);

    // LSU exception, drain with ALU/CSR pending, then normal grants
    tgt = '0; tgt[63:32] = 32'h8000_0100;
    rd = {5'd9, 5'd10, 5'd11};
    drive(3'b010, 3'b010, 3'b010, rd, res, tgt, 1'b0);
    for (int i = 0; i < FC + 1; i++) drive(3'b101, 3'b101, 3'b000, rd, res, tgt, 1'b0);
    for (int i = 0; i < 4; i++) drive(3'b111, 3'b111, 3'b000, rd, res, tgt, 1'b0);

    // Reset during the second drain cycle
    drive(3'b010, 3'b010, 3'b010, rd, res, tgt, 1'b0);
    drive(3'b111, 3'b111, 3'b000, rd, res, tgt, 1'b0);
    drive(3'b111, 3'b111, 3'b000, rd, res, tgt, 1'b1);
    drive(3'b001, 3'b001, 3'b000, rd, res, tgt, 1'b0);
    drive(3'b001, 3'b001, 3'b000, rd, res, tgt, 1'b0);

    // Idle
    for (int i = 0; i < 10; i++) drive('0, '0, '0, rd, res, tgt, 1'b0);
    drive(3'b111, 3'b111, 3'b000, rd, res, tgt, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      for (int s = 0; s < N; s++) begin
        rd[s*5 +: 5]      = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
        res[s*XLEN +: XLEN] = $urandom;
        tgt[s*XLEN +: XLEN] = $urandom;
        ex[s]             = ($urandom_range(0, 11) == 0);
      end
      drive(N'($urandom), N'($urandom), ex, rd, res, tgt, $urandom_range(0, 199) == 0);
    end

    drive('0, '0, '0, '0, '0, '0, 1'b0);
    drive('0, '0, '0, '0, '0, '0, 1'b0);
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
